// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: multi-cycle issue/writeback sequencer feeding the ALU from a 32x32 register file
module alu_issue_ctrl #(
  parameter logic [31:0] PC_RESET = 32'd0,
  parameter int          ALU_LAT  = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        INSTR_VALID,
  input  logic [31:0] INSTR,
  output logic        INSTR_READY,
  output logic [31:0] PC,
  output logic [5:0]  OPCODE,
  output logic [31:0] RS_VAL,
  output logic [31:0] RT_VAL,
  output logic [4:0]  SHAMT,
  output logic [5:0]  FUNC,
  output logic [15:0] RAW_VAL,
  input  logic [31:0] RESULT,
  input  logic        SIG_B,
  output logic        WB_VALID,
  output logic [4:0]  WB_ADDR,
  output logic [31:0] WB_DATA,
  input  logic        DBG_WE,
  input  logic [4:0]  DBG_ADDR,
  input  logic [31:0] DBG_WDATA,
  output logic [31:0] DBG_RDATA
);
  localparam logic [1:0] IDLE = 2'd0, DECODE = 2'd1, EXEC = 2'd2, WB = 2'd3;
  logic [1:0]  state;
  logic [31:0] instr, res, cnt;
  logic        sig, branch, wr;
  logic [4:0]  dest;
  logic [31:0] regs [32];
  assign branch      = instr[31:28] == 4'b0001;
  assign dest        = instr[31:26] == 6'd0 ? instr[15:11] : instr[20:16];
  assign wr          = state == WB && !branch && dest != 5'd0;
  assign INSTR_READY = RST_N && state == IDLE;
  assign WB_VALID    = RST_N && wr;
  assign WB_ADDR     = WB_VALID ? dest : 5'd0;
  assign WB_DATA     = WB_VALID ? res : 32'd0;
  assign DBG_RDATA   = regs[DBG_ADDR];
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state   <= IDLE;
      PC      <= PC_RESET;
      instr   <= '0;
      res     <= '0;
      sig     <= 1'b0;
      cnt     <= '0;
      OPCODE  <= '0;
      RS_VAL  <= '0;
      RT_VAL  <= '0;
      SHAMT   <= '0;
      FUNC    <= '0;
      RAW_VAL <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (INSTR_VALID) begin
            instr <= INSTR;
            state <= DECODE;
          end
          // R0 is never written so it always reads zero
          if (DBG_WE && DBG_ADDR != 5'd0) regs[DBG_ADDR] <= DBG_WDATA;
        end
        DECODE: begin
          OPCODE  <= instr[31:26];
          RS_VAL  <= regs[instr[25:21]];
          RT_VAL  <= regs[instr[20:16]];
          SHAMT   <= instr[10:6];
          FUNC    <= instr[5:0];
          RAW_VAL <= instr[15:0];
          cnt     <= '0;
          state   <= EXEC;
        end
        EXEC: begin
          if (cnt == 32'(ALU_LAT - 1)) begin
            res   <= RESULT;
            sig   <= SIG_B;
            state <= WB;
          end else cnt <= cnt + 32'd1;
        end
        default: begin
          PC    <= PC + 32'd1 + (branch && sig ? {{16{instr[15]}}, instr[15:0]} : 32'd0);
          if (wr) regs[dest] <= res;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
